// File: rtl/mem_bus_master.sv
// Initiator for the shared 8-bit multiplexed memory bus: address phase, then data phase,
// with single-byte writes and 1-4 byte incrementing read bursts.
module mem_bus_master #(
    parameter int READ_LATENCY = 1,
    parameter int DW           = 8
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [DW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    input  logic [1:0]    req_cnt,
    output logic [DW-1:0] rdata,
    output logic          rvalid,
    output logic          done,
    output logic          busy,
    output logic [DW-1:0] bus_out,
    output logic          bus_oe,
    input  logic [DW-1:0] bus_in,
    output logic          bus_addr_valid,
    output logic          bus_rd,
    output logic [1:0]    dbg_state
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ADDR  = 2'd1;
    localparam logic [1:0] WDATA = 2'd2;
    localparam logic [1:0] RWAIT = 2'd3;

    localparam logic [2:0]    LAT_INIT = 3'(READ_LATENCY);
    localparam logic [DW-1:0] ONE      = {{(DW-1){1'b0}}, 1'b1};

    logic [1:0]    state;
    logic [DW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          we_q;
    logic [1:0]    rem_q;
    logic [2:0]    lat_q;

    // Handshake: a request transfers on a rising edge where req_valid=1 and req_ready=1;
    // req_ready is high only in IDLE, and requests offered while busy are dropped, not queued.
    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign dbg_state = state;

    // Bus outputs are registered from the next state so they change cleanly on the edge.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state          <= IDLE;
            addr_q         <= '0;
            wdata_q        <= '0;
            we_q           <= 1'b0;
            rem_q          <= 2'd0;
            lat_q          <= 3'd0;
            rdata          <= '0;
            rvalid         <= 1'b0;
            done           <= 1'b0;
            bus_out        <= '0;
            bus_oe         <= 1'b0;
            bus_addr_valid <= 1'b0;
            bus_rd         <= 1'b0;
        end else begin
            rvalid <= 1'b0;
            done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q         <= req_addr;
                        wdata_q        <= req_wdata;
                        we_q           <= req_we;
                        rem_q          <= req_we ? 2'd0 : req_cnt;
                        state          <= ADDR;
                        bus_oe         <= 1'b1;
                        bus_addr_valid <= 1'b1;
                        bus_rd         <= ~req_we;
                        bus_out        <= req_addr;
                    end
                end
                ADDR: begin
                    bus_addr_valid <= 1'b0;
                    bus_rd         <= 1'b0;
                    if (we_q) begin
                        state   <= WDATA;
                        bus_out <= wdata_q;
                    end else begin
                        // Turnaround: release the bus so the responder can drive it.
                        state  <= RWAIT;
                        lat_q  <= LAT_INIT;
                        bus_oe <= 1'b0;
                    end
                end
                WDATA: begin
                    state  <= IDLE;
                    bus_oe <= 1'b0;
                    done   <= 1'b1;
                end
                RWAIT: begin
                    lat_q <= lat_q - 3'd1;
                    if (lat_q == 3'd1) begin
                        rdata  <= bus_in;
                        rvalid <= 1'b1;
                        if (rem_q != 2'd0) begin
                            rem_q          <= rem_q - 2'd1;
                            addr_q         <= addr_q + ONE;
                            state          <= ADDR;
                            bus_oe         <= 1'b1;
                            bus_addr_valid <= 1'b1;
                            bus_rd         <= 1'b1;
                            bus_out        <= addr_q + ONE;
                        end else begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_master.sv
// Bench for mem_bus_master: two instances (READ_LATENCY 1 and 3) each with a small memory
// responder; a negedge monitor scores address phases, write data and read bytes.
module tb_mem_bus_master;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    logic       req_we;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;
    logic [1:0] req_cnt;

    logic [1:0] valid_v;
    logic [1:0] ready_v, rvalid_v, done_v, busy_v, oe_v, av_v, rd_v;
    logic [7:0] rdata_v [2];
    logic [7:0] out_v [2];
    logic [7:0] in_v [2];
    logic [1:0] st_v [2];

    logic [7:0] mem [2][256];
    logic [7:0] ref_mem [2][256];
    logic [7:0] cur [2];
    logic       mem_ready = 1'b0;

    // Expected read bytes ({last, data}), address phases ({rd, addr}) and write data.
    logic [8:0] exp_q[$];
    logic [8:0] exp_aq[$];
    logic [7:0] exp_wq[$];

    int lat_of [2];
    int ncyc = 0;
    int last_av [2];
    logic [7:0] last_out [2];

    mem_bus_master #(.READ_LATENCY(1), .DW(8)) dut1 (
        .CLK(CLK), .RST(RST),
        .req_valid(valid_v[0]), .req_ready(ready_v[0]), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_cnt(req_cnt),
        .rdata(rdata_v[0]), .rvalid(rvalid_v[0]), .done(done_v[0]), .busy(busy_v[0]),
        .bus_out(out_v[0]), .bus_oe(oe_v[0]), .bus_in(in_v[0]),
        .bus_addr_valid(av_v[0]), .bus_rd(rd_v[0]), .dbg_state(st_v[0])
    );

    mem_bus_master #(.READ_LATENCY(3), .DW(8)) dut3 (
        .CLK(CLK), .RST(RST),
        .req_valid(valid_v[1]), .req_ready(ready_v[1]), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_cnt(req_cnt),
        .rdata(rdata_v[1]), .rvalid(rvalid_v[1]), .done(done_v[1]), .busy(busy_v[1]),
        .bus_out(out_v[1]), .bus_oe(oe_v[1]), .bus_in(in_v[1]),
        .bus_addr_valid(av_v[1]), .bus_rd(rd_v[1]), .dbg_state(st_v[1])
    );

    // Memory responder: latches the address phase, stores write-data phases, drives reads.
    always @(posedge CLK) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) begin
                mem[0][i] <= 8'(i) ^ 8'h10;
                mem[1][i] <= 8'(i) ^ 8'h10;
            end
            mem_ready <= 1'b1;
        end
        for (int k = 0; k < 2; k++) begin
            if (av_v[k]) cur[k] <= out_v[k];
            else if (oe_v[k]) mem[k][cur[k]] <= out_v[k];
        end
    end
    assign in_v[0] = oe_v[0] ? out_v[0] : mem[0][cur[0]];
    assign in_v[1] = oe_v[1] ? out_v[1] : mem[1][cur[1]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor
    always @(negedge CLK) begin
        ncyc++;
        for (int k = 0; k < 2; k++) begin
            if (rvalid_v[k]) begin
                chk("rvalid_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    chk("rdata", rdata_v[k], e[7:0]);
                    chk("done_on_last_only", done_v[k], e[8]);
                    chk("rvalid_after_addr", ncyc - last_av[k], lat_of[k] + 1);
                end
            end
            if (av_v[k]) begin
                chk("addr_expected", 32'(exp_aq.size() != 0), 1);
                if (exp_aq.size() != 0) begin
                    logic [8:0] a;
                    a = exp_aq.pop_front();
                    chk("addr_phase_out", out_v[k], a[7:0]);
                    chk("addr_phase_rd", rd_v[k], a[8]);
                    chk("addr_phase_oe", oe_v[k], 1);
                end
                last_av[k] = ncyc;
            end else if (oe_v[k]) begin
                chk("wdata_expected", 32'(exp_wq.size() != 0), 1);
                if (exp_wq.size() != 0) chk("wdata_phase_out", out_v[k], exp_wq.pop_front());
            end
            if (!RST) last_out[k] = 8'h00;
            else if (oe_v[k]) last_out[k] = out_v[k];
            else chk("bus_out_hold", out_v[k], last_out[k]);
        end
    end

    // Driver: call at #1 after a posedge; returns in the done cycle so the next call is back-to-back.
    task automatic run_txn(input int k, input logic we, input logic [7:0] addr,
                           input logic [7:0] wdata, input logic [1:0] cnt,
                           input int exp_cycles, input bit poke);
        int cyc;
        chk("ready_when_idle", ready_v[k], 1);
        req_we = we; req_addr = addr; req_wdata = wdata; req_cnt = cnt;
        if (we) begin
            exp_aq.push_back({1'b0, addr});
            exp_wq.push_back(wdata);
            ref_mem[k][addr] = wdata;
        end else begin
            for (int i = 0; i <= int'(cnt); i++) begin
                exp_aq.push_back({1'b1, 8'(addr + 8'(i))});
                exp_q.push_back({(i == int'(cnt)), ref_mem[k][8'(addr + 8'(i))]});
            end
        end
        valid_v[k] = 1'b1;
        @(posedge CLK); #1;
        valid_v[k] = 1'b0;
        cyc = 1;
        while (!done_v[k] && cyc < 60) begin
            if (poke && cyc >= 3 && cyc <= 8) begin
                valid_v[k] = 1'b1;
                chk("ready_low_mid_burst", ready_v[k], 0);
            end else begin
                valid_v[k] = 1'b0;
            end
            @(posedge CLK); #1;
            cyc++;
        end
        valid_v[k] = 1'b0;
        chk("done_latency", cyc, exp_cycles);
    endtask

    typedef struct {
        int         k;
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [1:0] cnt;
        int         exp_cycles;
    } vec_t;

    vec_t vecs [10];

    initial begin
        lat_of[0] = 1; lat_of[1] = 3;
        last_av[0] = 0; last_av[1] = 0;
        last_out[0] = 8'h00; last_out[1] = 8'h00;
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 256; i++) ref_mem[k][i] = 8'(i) ^ 8'h10;

        vecs[0] = '{0, 1'b0, 8'h01, 8'h00, 2'd0, 3};
        vecs[1] = '{0, 1'b0, 8'h00, 8'h00, 2'd3, 9};
        vecs[2] = '{0, 1'b1, 8'hFF, 8'hAA, 2'd0, 3};
        vecs[3] = '{0, 1'b0, 8'hFF, 8'h00, 2'd0, 3};
        vecs[4] = '{0, 1'b0, 8'hFE, 8'h00, 2'd1, 5};
        vecs[5] = '{1, 1'b0, 8'h00, 8'h00, 2'd0, 5};
        vecs[6] = '{1, 1'b1, 8'h40, 8'h5A, 2'd3, 3};
        vecs[7] = '{1, 1'b0, 8'h3F, 8'h00, 2'd2, 13};
        vecs[8] = '{0, 1'b1, 8'h00, 8'hC3, 2'd0, 3};
        vecs[9] = '{0, 1'b0, 8'hFF, 8'h00, 2'd1, 5};

        // Reset held with a request pending
        valid_v = 2'b11; req_we = 1'b0; req_addr = 8'h01; req_wdata = 8'h00; req_cnt = 2'd0;
        RST = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_ready", ready_v[k], 1);
            chk("rst_busy", busy_v[k], 0);
            chk("rst_rvalid", rvalid_v[k], 0);
            chk("rst_done", done_v[k], 0);
            chk("rst_oe", oe_v[k], 0);
            chk("rst_addr_valid", av_v[k], 0);
            chk("rst_rd", rd_v[k], 0);
            chk("rst_bus_out", out_v[k], 8'h00);
            chk("rst_rdata", rdata_v[k], 8'h00);
        end
        RST = 1'b1; valid_v = 2'b00;
        @(posedge CLK); #1;
        chk("post_rst_idle", busy_v[0] | busy_v[1], 0);

        for (int i = 0; i < 10; i++)
            run_txn(vecs[i].k, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].cnt,
                    vecs[i].exp_cycles, 1'b0);

        // Wrap with READ_LATENCY=3 while a second request is offered mid-burst
        run_txn(1, 1'b0, 8'hFE, 8'h00, 2'd2, 13, 1'b1);

        // Random reads and writes on both instances
        for (int i = 0; i < 8; i++) begin
            int k;
            logic we;
            logic [1:0] c;
            k = int'($urandom_range(0, 1));
            we = 1'($urandom_range(0, 1));
            c = 2'($urandom_range(0, 3));
            run_txn(k, we, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), c,
                    we ? 3 : 1 + (int'(c) + 1) * (lat_of[k] + 1), 1'b0);
        end

        // Abort a burst during RWAIT
        req_we = 1'b0; req_addr = 8'h20; req_cnt = 2'd3;
        exp_aq.push_back({1'b1, 8'h20});
        valid_v[0] = 1'b1;
        @(posedge CLK); #1;
        valid_v[0] = 1'b0;
        @(posedge CLK); #1;
        chk("abort_in_rwait", st_v[0], 2'd3);
        RST = 1'b0;
        @(posedge CLK); #1;
        chk("abort_oe", oe_v[0], 0);
        chk("abort_rvalid", rvalid_v[0], 0);
        chk("abort_done", done_v[0], 0);
        chk("abort_busy", busy_v[0], 0);
        chk("abort_rdata", rdata_v[0], 8'h00);
        @(posedge CLK); #1;
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        chk("abort_no_rvalid", rvalid_v[0] | done_v[0], 0);
        run_txn(0, 1'b0, 8'h02, 8'h00, 2'd1, 5, 1'b0);

        repeat (3) @(posedge CLK);
        #1;
        chk("exp_q_drained", exp_q.size(), 0);
        chk("exp_aq_drained", exp_aq.size(), 0);
        chk("exp_wq_drained", exp_wq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
